// File: rtl/mru_share_ctrl.sv
// Round-robin shared access to a 4-entry most-recently-used history.
// Optional hit/miss statistics counters are built in when MRU_STATS_EN is defined.
module mru_share_ctrl #(
   parameter  int DATA_W = 8,
   parameter  int ID_W   = 2,
   localparam int N_REQ  = 2**ID_W
) (
   input  logic                    clk_in,
   input  logic                    reset_in,
   input  logic                    flush_in,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   output logic [N_REQ-1:0]        req_ready,
   output logic                    rsp_valid,
   output logic [ID_W-1:0]         rsp_id,
   output logic [DATA_W-1:0]       rsp_data,
   output logic                    rsp_hit,
   output logic [1:0]              rsp_pos,
   output logic [DATA_W-1:0]       mru_0,
   output logic [DATA_W-1:0]       mru_1,
   output logic [DATA_W-1:0]       mru_2,
   output logic [DATA_W-1:0]       mru_3,
   output logic [3:0]              mru_valid
`ifdef MRU_STATS_EN
   ,
   output logic [15:0]             hit_cnt,
   output logic [15:0]             miss_cnt
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_UPDATE} state_t;

   state_t            r_state, w_next;
   logic [ID_W-1:0]   r_ptr, r_id, w_gnt_id, w_idx;
   logic              w_gnt_any;
   logic [DATA_W-1:0] r_word;
   logic [DATA_W-1:0] r_mru [4];
   logic [3:0]        r_mru_valid;
   logic              w_hit, r_hit;
   logic [1:0]        w_pos, r_pos;
   logic              r_rsp_valid, r_rsp_hit;
   logic [ID_W-1:0]   r_rsp_id;
   logic [DATA_W-1:0] r_rsp_data;
   logic [1:0]        r_rsp_pos;

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_in) begin
      if (reset_in || flush_in) r_state <= S_IDLE;
      else                      r_state <= w_next;
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (w_gnt_any) w_next = S_LOOKUP;
         S_LOOKUP: w_next = S_UPDATE;
         S_UPDATE: w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Scan downward so the requester closest to the pointer is the last (winning) match.
   always_comb begin
      w_gnt_any = 1'b0;
      w_gnt_id  = '0;
      w_idx     = '0;
      for (int k = N_REQ-1; k >= 0; k--) begin
         w_idx = r_ptr + ID_W'(k);
         if (req_valid[w_idx]) begin
            w_gnt_any = 1'b1;
            w_gnt_id  = w_idx;
         end
      end
      if (r_state != S_IDLE || flush_in || reset_in) w_gnt_any = 1'b0;
   end

   always_comb begin
      req_ready = '0;
      if (w_gnt_any) req_ready = N_REQ'(1) << w_gnt_id;
   end

   always_comb begin
      w_hit = 1'b0;
      w_pos = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         if (r_mru_valid[k] && r_mru[k] == r_word) begin
            w_hit = 1'b1;
            w_pos = 2'(k);
         end
      end
   end

   // NOTE: the history is a visible, valid-tagged register file, so it is explicitly reset and flushed.
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         r_ptr       <= '0;
         r_id        <= '0;
         r_word      <= '0;
         r_hit       <= 1'b0;
         r_pos       <= 2'd0;
         r_mru_valid <= 4'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= '0;
         r_rsp_data  <= '0;
         r_rsp_hit   <= 1'b0;
         r_rsp_pos   <= 2'd0;
         for (int k = 0; k < 4; k++) r_mru[k] <= '0;
      end else if (flush_in) begin
         r_ptr       <= '0;
         r_mru_valid <= 4'b0;
         r_rsp_valid <= 1'b0;
         for (int k = 0; k < 4; k++) r_mru[k] <= '0;
      end else begin
         r_rsp_valid <= 1'b0;
         if (w_gnt_any) begin
            r_word <= req_data[w_gnt_id*DATA_W +: DATA_W];
            r_id   <= w_gnt_id;
            r_ptr  <= w_gnt_id + 1'b1;
         end
         if (r_state == S_LOOKUP) begin
            r_hit <= w_hit;
            r_pos <= w_pos;
         end
         if (r_state == S_UPDATE) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_data  <= r_word;
            r_rsp_hit   <= r_hit;
            r_rsp_pos   <= r_pos;
            r_mru[0]    <= r_word;
            // A miss shifts the whole list; a hit only shifts the entries above the hit slot.
            for (int k = 1; k < 4; k++)
               if (!r_hit || k <= int'(r_pos)) r_mru[k] <= r_mru[k-1];
            if (!r_hit) r_mru_valid <= {r_mru_valid[2:0], 1'b1};
         end
      end
   end

`ifdef MRU_STATS_EN
   logic [15:0] r_hit_cnt, r_miss_cnt;

   always_ff @(posedge clk_in) begin
      if (reset_in || flush_in) begin
         r_hit_cnt  <= 16'd0;
         r_miss_cnt <= 16'd0;
      end else if (r_state == S_UPDATE) begin
         if (r_hit && r_hit_cnt != 16'hFFFF)    r_hit_cnt  <= r_hit_cnt + 16'd1;
         if (!r_hit && r_miss_cnt != 16'hFFFF)  r_miss_cnt <= r_miss_cnt + 16'd1;
      end
   end

   assign hit_cnt  = r_hit_cnt;
   assign miss_cnt = r_miss_cnt;
`else
   // Statistics counters are not built in this configuration.
`endif

   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_rsp_id;
   assign rsp_data  = r_rsp_data;
   assign rsp_hit   = r_rsp_hit;
   assign rsp_pos   = r_rsp_pos;
   assign mru_0     = r_mru[0];
   assign mru_1     = r_mru[1];
   assign mru_2     = r_mru[2];
   assign mru_3     = r_mru[3];
   assign mru_valid = r_mru_valid;

endmodule

// File: tb/tb_mru_share_ctrl.sv
// Directed bench for mru_share_ctrl: table of single transactions plus
// round-robin, flush and (with MRU_STATS_EN) statistics sequences.
module tb_mru_share_ctrl;

   localparam int DATA_W = 8;
   localparam int ID_W   = 2;
   localparam int N_REQ  = 4;

   logic                    clk_in = 1'b0;
   logic                    reset_in, flush_in;
   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ-1:0]        req_ready;
   logic                    rsp_valid, rsp_hit;
   logic [ID_W-1:0]         rsp_id;
   logic [DATA_W-1:0]       rsp_data;
   logic [1:0]              rsp_pos;
   logic [DATA_W-1:0]       mru_0, mru_1, mru_2, mru_3;
   logic [3:0]              mru_valid;
`ifdef MRU_STATS_EN
   logic [15:0]             hit_cnt, miss_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk_in = ~clk_in;

   mru_share_ctrl #(.DATA_W(DATA_W), .ID_W(ID_W)) dut (
      .clk_in    (clk_in),
      .reset_in  (reset_in),
      .flush_in  (flush_in),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .rsp_hit   (rsp_hit),
      .rsp_pos   (rsp_pos),
      .mru_0     (mru_0),
      .mru_1     (mru_1),
      .mru_2     (mru_2),
      .mru_3     (mru_3),
      .mru_valid (mru_valid)
`ifdef MRU_STATS_EN
      ,
      .hit_cnt   (hit_cnt),
      .miss_cnt  (miss_cnt)
`endif
   );

   typedef struct {
      int         id;
      logic [7:0] d;
      logic       hit;
      logic [1:0] pos;
      logic [31:0] list;   // {mru_0, mru_1, mru_2, mru_3}
      logic [3:0] val;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk_in);
      reset_in  = 1'b1;
      flush_in  = 1'b0;
      req_valid = 4'hF;
      req_data  = '0;
      @(negedge clk_in);
      #1;
      check("ready_in_reset", req_ready, 4'h0);
      @(negedge clk_in);
      reset_in  = 1'b0;
      req_valid = 4'h0;
   endtask

   // Issues one request at a negedge and checks the response three cycles after the handshake.
   task automatic txn(input string nm, input int id, input logic [7:0] d, input logic e_hit,
                      input logic [1:0] e_pos, input logic [31:0] e_list, input logic [3:0] e_val);
      int n = 0;
      req_valid[id]         = 1'b1;
      req_data[id*8 +: 8]   = d;
      #1;
      while (req_ready !== (4'b1 << id) && n < 20) begin
         @(negedge clk_in);
         #1;
         n++;
      end
      check({nm, " grant"}, req_ready, 4'b1 << id);
      @(negedge clk_in);
      req_valid[id]       = 1'b0;
      req_data[id*8 +: 8] = ~d;
      check({nm, " c1_no_rsp"}, rsp_valid, 1'b0);
      @(negedge clk_in);
      check({nm, " c2_no_rsp"}, rsp_valid, 1'b0);
      @(negedge clk_in);
      check({nm, " rsp_valid"}, rsp_valid, 1'b1);
      check({nm, " rsp_id"},    rsp_id, id);
      check({nm, " rsp_data"},  rsp_data, d);
      check({nm, " rsp_hit"},   rsp_hit, e_hit);
      check({nm, " rsp_pos"},   rsp_pos, e_pos);
      check({nm, " list"},      {mru_0, mru_1, mru_2, mru_3}, e_list);
      check({nm, " valid"},     mru_valid, e_val);
      @(negedge clk_in);
      check({nm, " rsp_one_cycle"}, rsp_valid, 1'b0);
   endtask

   initial begin
      int gid [8];
      int gcyc [8];
      int rid [8];
      int gn, rn;
      logic drop;

      reset_in  = 1'b1;
      flush_in  = 1'b0;
      req_valid = '0;
      req_data  = '0;

      vecs[0] = '{0, 8'h00, 1'b0, 2'd0, 32'h00000000, 4'b0001};
      vecs[1] = '{1, 8'h11, 1'b0, 2'd0, 32'h11000000, 4'b0011};
      vecs[2] = '{1, 8'h22, 1'b0, 2'd0, 32'h22110000, 4'b0111};
      vecs[3] = '{1, 8'h33, 1'b0, 2'd0, 32'h33221100, 4'b1111};
      vecs[4] = '{1, 8'h44, 1'b0, 2'd0, 32'h44332211, 4'b1111};
      vecs[5] = '{1, 8'h22, 1'b1, 2'd2, 32'h22443311, 4'b1111};
      vecs[6] = '{3, 8'h22, 1'b1, 2'd0, 32'h22443311, 4'b1111};
      vecs[7] = '{2, 8'h11, 1'b1, 2'd3, 32'h11224433, 4'b1111};
      vecs[8] = '{0, 8'h55, 1'b0, 2'd0, 32'h55112244, 4'b1111};
      vecs[9] = '{1, 8'h00, 1'b0, 2'd0, 32'h00551122, 4'b1111};

      do_reset();
      check("reset rsp_valid", rsp_valid, 1'b0);
      check("reset rsp_fields", {rsp_id, rsp_data, rsp_hit, rsp_pos}, '0);
      check("reset list", {mru_0, mru_1, mru_2, mru_3}, 32'h0);
      check("reset valid", mru_valid, 4'b0);

      for (int i = 0; i < 10; i++)
         txn($sformatf("vec%0d", i), vecs[i].id, vecs[i].d, vecs[i].hit, vecs[i].pos,
             vecs[i].list, vecs[i].val);

      // Round robin with all requesters continuously valid.
      do_reset();
      req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      req_valid = 4'hF;
      gn = 0; rn = 0; drop = 1'b0;
      for (int i = 0; i < 8; i++) begin gid[i] = -1; gcyc[i] = -1; rid[i] = -1; end
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (cyc != 0) @(negedge clk_in);
         if (drop) req_valid = 4'h0;
         #1;
         if (rsp_valid && rn < 8) begin rid[rn] = int'(rsp_id); rn++; end
         if (|req_ready && gn < 8) begin
            for (int k = 0; k < N_REQ; k++) if (req_ready[k]) gid[gn] = k;
            gcyc[gn] = cyc;
            gn++;
            if (gn == 8) drop = 1'b1;
         end
      end
      check("rr grant_count", gn, 8);
      check("rr rsp_count", rn, 8);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("rr grant%0d", i), gid[i], i % 4);
         check($sformatf("rr rsp_id%0d", i), rid[i], i % 4);
         if (i > 0) check($sformatf("rr spacing%0d", i), gcyc[i] - gcyc[i-1], 3);
      end

      // Flush during LOOKUP drops the request and clears the history and pointer.
      do_reset();
      txn("pre_flush", 0, 8'h12, 1'b0, 2'd0, 32'h12000000, 4'b0001);
      req_valid[2] = 1'b1;
      req_data[16 +: 8] = 8'h77;
      #1;
      check("flush grant", req_ready, 4'b0100);
      @(negedge clk_in);
      req_valid[2] = 1'b0;
      flush_in = 1'b1;
      @(negedge clk_in);
      flush_in = 1'b0;
      check("flush valid_cleared", mru_valid, 4'b0);
      check("flush list_cleared", {mru_0, mru_1, mru_2, mru_3}, 32'h0);
      check("flush no_rsp_a", rsp_valid, 1'b0);
      @(negedge clk_in);
      check("flush no_rsp_b", rsp_valid, 1'b0);
      @(negedge clk_in);
      check("flush no_rsp_c", rsp_valid, 1'b0);
      req_valid = 4'b1001;
      req_data  = {8'h34, 8'h00, 8'h00, 8'h12};
      #1;
      check("flush ptr_zero_grant", req_ready, 4'b0001);
      @(negedge clk_in);
      req_valid = 4'h0;
      @(negedge clk_in);
      @(negedge clk_in);
      check("post_flush rsp_valid", rsp_valid, 1'b1);
      check("post_flush rsp_id", rsp_id, 2'd0);
      check("post_flush miss", rsp_hit, 1'b0);
      check("post_flush valid", mru_valid, 4'b0001);

      // No grant from IDLE while flush is held.
      @(negedge clk_in);
      flush_in  = 1'b1;
      req_valid = 4'b0010;
      #1;
      check("flush_idle no_grant", req_ready, 4'h0);
      @(negedge clk_in);
      flush_in  = 1'b0;
      req_valid = 4'h0;

`ifdef MRU_STATS_EN
      do_reset();
      txn("st0", 0, 8'h01, 1'b0, 2'd0, 32'h01000000, 4'b0001);
      txn("st1", 1, 8'h02, 1'b0, 2'd0, 32'h02010000, 4'b0011);
      txn("st2", 2, 8'h03, 1'b0, 2'd0, 32'h03020100, 4'b0111);
      txn("st3", 3, 8'h01, 1'b1, 2'd2, 32'h01030200, 4'b0111);
      txn("st4", 0, 8'h02, 1'b1, 2'd2, 32'h02010300, 4'b0111);
      check("stats miss_cnt", miss_cnt, 16'd3);
      check("stats hit_cnt", hit_cnt, 16'd2);
      flush_in = 1'b1;
      @(negedge clk_in);
      flush_in = 1'b0;
      check("stats miss_flushed", miss_cnt, 16'd0);
      check("stats hit_flushed", hit_cnt, 16'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mru_share_ctrl.md
# mru_share_ctrl

Shared-access controller for a 4-entry most-recently-used (MRU) value history. It arbitrates between up to four requesters with round-robin priority and accepts one data word at a time. Each accepted word is looked up in the history, the history is updated by move-to-front or push, and a hit/miss response tagged with the requester ID is returned. It sits between several producer channels and the single distinct-value history they share.

## Interface
- DATA_W, 8, width of each data word and history entry
- ID_W, 2, requester ID width; number of requesters N_REQ = 2**ID_W (supported values 1..2)
- clk_in  input  1  clock; all logic on rising edge
- reset_in  input  1  synchronous, active-high reset
- flush_in  input  1  synchronous clear of history and any in-flight request
- req_valid  input  N_REQ  per-requester request valid
- req_data  input  N_REQ*DATA_W  requester i data in bits [i*DATA_W +: DATA_W]
- req_ready  output  N_REQ  one-hot grant; combinational from state, req_valid and priority pointer
- rsp_valid  output  1  one-cycle response strobe
- rsp_id  output  ID_W  requester ID of the response
- rsp_data  output  DATA_W  looked-up word
- rsp_hit  output  1  1 = word found in a valid history entry
- rsp_pos  output  2  hit position 0..3; 0 on miss
- mru_0..mru_3  output  DATA_W each  history entries, 0 = most recent
- mru_valid  output  4  per-entry valid, bit k belongs to mru_k

## Operation
- FSM states are IDLE, LOOKUP and UPDATE.
- IDLE: if any req_valid is high and flush_in is low, grant exactly one requester: the first valid one scanning upward from the pointer, with wrap. On valid&ready, capture data and ID and go to LOOKUP. req_ready is all-zero outside IDLE.
- Pointer: after a grant to requester i, the pointer becomes (i+1) mod N_REQ. Reset and flush set it to 0.
- LOOKUP: compare the captured word with mru_k only where mru_valid[k]=1. Lowest matching k wins; entries are distinct by construction. Register hit/pos and go to UPDATE.
- UPDATE on hit at position p:
  - mru_0 <= word.
  - mru_k <= mru_(k-1) for 1 <= k <= p.
  - Entries above p are unchanged; mru_valid is unchanged.
  - A hit at p=0 leaves the list unchanged.
- UPDATE on miss:
  - Full shift: mru_0 <= word, mru_k <= mru_(k-1), and mru_3 is discarded.
  - mru_valid <= {mru_valid[2:0], 1}.
- UPDATE always asserts rsp_valid/rsp_id/rsp_data/rsp_hit/rsp_pos (registered) and returns to IDLE.
- Invalid entries never produce a hit, so a word equal to 0 after reset is a miss.
- flush_in in any state:
  - next cycle: all mru_k=0, mru_valid=0, state IDLE, rsp_valid=0.
  - An in-flight request is dropped with no response.
  - In IDLE, no grant occurs while flush_in=1.
- reset_in has priority over flush_in and clears everything below.

## Timing
- Reset values: req_ready=0 while reset_in=1; rsp_valid=0, rsp_id=0, rsp_data=0, rsp_hit=0, rsp_pos=0, mru_0..3=0, mru_valid=0, state IDLE, pointer 0.
- Handshake completes at the end of cycle C0 (req_valid[i]&req_ready[i]).
- C1 = LOOKUP, C2 = UPDATE.
- C3: rsp_valid=1 for exactly one cycle. mru_* and mru_valid show the updated list in the same cycle.
- State is IDLE in C3, so a new grant may occur in C3. Peak throughput is one request per 3 cycles.
- req_data is sampled only in C0; requesters may change it afterwards.
- A requester holding req_valid without a grant keeps waiting; there is no timeout.
- With all N_REQ requesters continuously valid, grants rotate 0,1,2,3,0…; a single requester is never granted twice while another is waiting.

## Configuration
- MRU_STATS_EN defined:
  - Adds outputs hit_cnt and miss_cnt, 16 bits each.
  - Each counts completed responses of its kind.
  - Both saturate at 16'hFFFF.
  - Both are cleared by reset_in and flush_in.
  - A dropped (flushed) request is not counted.
- MRU_STATS_EN undefined: these ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset, then requester 0 sends 8'h00 -> rsp_hit=0, mru_0=8'h00, mru_valid=4'b0001, rsp_valid in C3.
- Requester 1 sends 8'h11, 8'h22, 8'h33, 8'h44, then 8'h22 -> last response rsp_hit=1, rsp_pos=2, rsp_id=1; list becomes 22,44,33,11 with mru_valid=4'b1111.
- Fifth distinct word 8'h55 after a full list 44,33,22,11 -> miss; list becomes 55,44,33,22; 11 is evicted.
- All four req_valid held high for 8 grants -> grant order 0,1,2,3,0,1,2,3; one grant every 3 cycles; rsp_id matches.
- flush_in asserted in the LOOKUP cycle -> no rsp_valid for that request; next cycle mru_valid=0 and pointer 0; the next request is granted from IDLE.
- With MRU_STATS_EN: 3 misses then 2 hits -> miss_cnt=3, hit_cnt=2; flush -> both 0.
